// File: rtl/inst_fetch_stage_if.sv
// inst_fetch_stage_if: instruction ROM port plus the IF/ID handshake and redirect signals.
interface inst_fetch_stage_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       inst;
    logic              id_allow_in;
    logic              br_valid;
    logic [31:0]       br_target;
    logic              halt;
    logic              if_valid;
    logic [31:0]       if_inst;
    logic [31:0]       if_pc;
    logic [31:0]       pc;
    logic [31:0]       fetch_count;

    modport master (
        input  inst, id_allow_in, br_valid, br_target, halt,
        output inst_addr, if_valid, if_inst, if_pc, pc, fetch_count
    );

    modport slave (
        output inst, id_allow_in, br_valid, br_target, halt,
        input  inst_addr, if_valid, if_inst, if_pc, pc, fetch_count
    );
endinterface

// File: rtl/inst_fetch_stage.sv
// inst_fetch_stage: owns the PC, reads the instruction ROM and hands words to decode,
// applying branch redirects after the delay slot without squashing anything.
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 5
) (
    input  logic               clk,
    input  logic               resetn,
    inst_fetch_stage_if.master bus
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_if_inst, r_if_pc, r_fetch_count, r_redir_target;
    logic        r_if_valid, r_redir_valid;
    logic        w_adv;
    logic [31:0] w_br_target, w_pc_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        case (r_state)
            S_BOOT: w_state_nxt = S_RUN;
            S_RUN: begin
                w_adv = !r_if_valid || bus.id_allow_in;
                if (bus.halt) w_state_nxt = S_HALT;
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // A fresh branch beats a stored one; the stored one beats sequential fetch.
    assign w_br_target = bus.br_target & ~32'h3;
    assign w_pc_nxt    = bus.br_valid ? w_br_target : r_redir_valid ? r_redir_target : r_pc + 32'd4;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_BOOT;
            r_pc           <= RESET_PC;
            r_if_valid     <= 1'b0;
            r_if_inst      <= '0;
            r_if_pc        <= '0;
            r_fetch_count  <= '0;
            r_redir_valid  <= 1'b0;
            r_redir_target <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_adv) begin
                r_if_inst     <= bus.inst;
                r_if_pc       <= r_pc;
                r_if_valid    <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
                r_pc          <= w_pc_nxt;
                r_redir_valid <= 1'b0;
            end else begin
                if (bus.br_valid) begin
                    r_redir_valid  <= 1'b1;
                    r_redir_target <= w_br_target;
                end
                if (bus.id_allow_in) r_if_valid <= 1'b0;
            end
        end
    end

    assign bus.inst_addr   = r_pc[ADDR_W+1:2];
    assign bus.if_valid    = r_if_valid;
    assign bus.if_inst     = r_if_inst;
    assign bus.if_pc       = r_if_pc;
    assign bus.pc          = r_pc;
    assign bus.fetch_count = r_fetch_count;
endmodule

// File: doc/inst_fetch_stage.md
# inst_fetch_stage

Instruction fetch stage for the pipelined CPU. It owns the program counter and drives the word address into the combinational instruction ROM, then captures the returned word. It presents each fetched instruction and its PC to decode through a valid/allow-in handshake, and applies branch/jump redirects from decode using MIPS delay-slot semantics (no flush). It sits between the instruction ROM and the IF/ID boundary.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `ADDR_W`, 5: width of the ROM word address, equal to PC bits [ADDR_W+1:2].
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `resetn`  input  1  asynchronous, active-low reset.
- `inst_addr`  output  ADDR_W  ROM word address, combinationally equal to `pc[ADDR_W+1:2]`.
- `inst`  input  32  ROM data for `inst_addr`, valid in the same cycle.
- `id_allow_in`  input  1  decode can accept a new instruction this cycle.
- `br_valid`  input  1  one-cycle pulse: decode has resolved a taken branch/jump.
- `br_target`  input  32  redirect target, qualified by `br_valid`; bits [1:0] ignored.
- `halt`  input  1  one-cycle pulse: stop fetching (break/syscall in decode).
- `if_valid`  output  1  `if_inst` and `if_pc` hold a valid instruction for decode.
- `if_inst`  output  32  registered instruction word.
- `if_pc`  output  32  registered PC of `if_inst`.
- `pc`  output  32  current fetch PC, for the debug display.
- `fetch_count`  output  32  number of instructions handed to decode.

## Operation
- State machine `BOOT -> RUN -> HALT`. Reset forces `BOOT`. `BOOT` moves to `RUN` unconditionally after one cycle. `RUN` moves to `HALT` on `halt`. `HALT` is left only by reset.
- Advance condition: `adv = (state==RUN) && (!if_valid || id_allow_in)`.
- On `adv`:
  - `if_inst <= inst`, `if_pc <= pc`, `if_valid <= 1`.
  - `fetch_count <= fetch_count + 1`.
  - `pc <=` next PC, chosen by priority: `br_valid` gives `{br_target[31:2],2'b00}`; otherwise the pending redirect gives its stored target; otherwise `pc + 4`.
- Delay slot: the instruction fetched in the cycle after the branch entered decode is the delay slot. It is kept. The redirect applies to the next fetch, and nothing is squashed.
- Pending redirect: if `br_valid` arrives while `adv==0`, latch `redir_valid<=1` and store the aligned target. The next `adv` consumes it and clears `redir_valid`. A second `br_valid` before consumption overwrites the stored target.
- Stall: `if_valid && !id_allow_in` holds `pc`, `if_inst`, `if_pc`, `if_valid` and `fetch_count` unchanged.
- In `BOOT` and `HALT` there is no advance. `if_valid` clears when `id_allow_in==1`, so the last instruction drains and is not refetched.
- `halt` and `adv` in the same cycle: that fetch completes, then `HALT` is entered. `halt` outside `RUN` is ignored.
- Arithmetic: `pc` and `fetch_count` are 32-bit modulo 2^32. `inst_addr` wraps every 2^(ADDR_W+2) bytes. Out-of-range ROM words read as 0 (nop) and are fetched normally.

## Timing
- Reset values:
  - `pc=RESET_PC`, `if_valid=0`, `if_inst=0`, `if_pc=0`, `fetch_count=0`.
  - `redir_valid=0`, stored redirect target 0, state `BOOT`.
- `inst_addr` is `pc[ADDR_W+1:2]` at all times, including during reset.
- Latency:
  - The first `if_valid=1` appears at the end of the 2nd rising edge after `resetn` deasserts.
  - The ROM-to-`if_inst` latency is 1 cycle.
  - In steady state the stage delivers 1 instruction per cycle with `id_allow_in=1`.
- Redirect: with `br_valid` at edge N, the `adv` at N loads `pc=target`. `if_pc==target` appears after the next `adv`.
- Asynchronous reset mid-run clears all state immediately, including a pending redirect. Fetch restarts from `RESET_PC` via `BOOT`.

## Test plan
- Reset, release, `id_allow_in=1`:
  - `if_valid` rises on the 2nd edge with `if_pc=0`, `if_inst=32'h24010001`.
  - The next edge gives `if_pc=4`, `if_inst=32'h00011100`.
  - `fetch_count` counts 1, 2, 3…
- Stall: drop `id_allow_in` while `if_pc=8` for 3 cycles.
  - Outputs hold `if_pc=8`, `inst_addr=3` and `fetch_count`.
  - On release, the next edge gives `if_pc=12`.
- Branch with advance: pulse `br_valid` with `br_target=32'h0000_0000` while `pc=32'h14`.
  - The delay slot `if_pc=32'h14` is delivered.
  - The following instruction has `if_pc=0`, `if_inst=32'h24010001`.
- Branch during stall: pulse `br_valid` with `br_target=32'h0000_0023` while stalled.
  - On release, the next fetch is at `pc=32'h20` (low bits dropped).
  - The delivered instruction after that has `if_pc=32'h20`, `if_inst=32'h08000000`.
- Halt: pulse `halt` at `if_pc=32'h10`.
  - At most one further instruction is delivered.
  - `if_valid` then goes 0 and `fetch_count` freezes for 20 cycles.
  - Reset restarts at `pc=0`.
- Wrap and reset mid-run:
  - Run to `pc=32'h7C`. Next gives `pc=32'h80`, `inst_addr=0`, `if_inst=32'h24010001`.
  - Assert `resetn=0` mid-cycle with a pending redirect: all outputs return to reset values immediately, and the redirect is lost.
